// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a UART TX shift stage: queues bus writes and issues a
// one-cycle parallel-load strobe whenever the transmitter reports idle.
module uart_tx_feeder #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [7:0] wdata,
  input  logic       clr_ovf,
  input  logic       ts,
  output logic [7:0] d_out,
  output logic       load,
  output logic       full,
  output logic       empty,
  output logic [4:0] count,
  output logic       ovf,
  output logic       busy
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    wptr_q;
  logic [PTR_W-1:0]    rptr_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic [DATA_W-1:0]   d_out_q;
  logic                load_q;
  logic                ovf_q;
  logic                full_c;
  logic                empty_c;
  logic                push_c;
  logic                pop_c;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign push_c  = we && !full_c;
  assign pop_c   = (state_q == IDLE) && !empty_c && ts;

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (!rst && push_c) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      state_q <= IDLE;
      d_out_q <= '0;
      load_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      load_q  <= 1'b0;
      if (push_c) begin
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      // A dropped write wins over a same-cycle clear.
      if (we && full_c) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (pop_c) begin
            d_out_q <= mem_q[rptr_q];
            load_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: state_q <= WAIT;
        WAIT: begin
          if (ts) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign d_out = d_out_q;
  assign load  = load_q;
  assign full  = full_c;
  assign empty = empty_c;
  assign count = count_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q != IDLE) || !empty_c;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: reset, single byte, burst, overflow,
// pointer wrap, simultaneous push/pop and reset during WAIT.
module tb_uart_tx_feeder;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [7:0] wdata;
  logic       clr_ovf;
  logic       ts;
  logic [7:0] d_out;
  logic       load;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       ovf;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int tx_cnt = 0;
  logic [7:0] wr_q [$];
  logic [7:0] exp_q [$];

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .wdata   (wdata),
    .clr_ovf (clr_ovf),
    .ts      (ts),
    .d_out   (d_out),
    .load    (load),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .ovf     (ovf),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Writes wr_q (one byte, then gap idle cycles) while a TX model holds ts low
  // for 'hold' cycles after each load; every load must deliver the next exp_q byte.
  task automatic run_tx(input int hold, input int gap, input int max_cycles);
    int   gapc = 0;
    logic prev_load = 1'b0;
    for (int c = 0; c < max_cycles && (exp_q.size() > 0 || wr_q.size() > 0 || tx_cnt > 0); c++) begin
      if (wr_q.size() > 0 && gapc == 0) begin
        we    = 1'b1;
        wdata = wr_q.pop_front();
        gapc  = gap;
      end else begin
        we = 1'b0;
        if (gapc > 0) gapc--;
      end
      step();
      we = 1'b0;
      if (load === 1'b1) begin
        chk("load_single_cycle", 32'(prev_load), 32'd0);
        if (exp_q.size() == 0) begin
          chk("extra_load", 32'(load), 32'd0);
        end else begin
          chk("load_data", 32'(d_out), 32'(exp_q.pop_front()));
        end
        ts     = 1'b0;
        tx_cnt = hold;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) ts = 1'b1;
      end
      prev_load = load;
    end
    chk("tx_all_delivered", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wdata = '0; clr_ovf = 1'b0; ts = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_load",  32'(load),  32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_ovf",   32'(ovf),   32'd0);
    chk("rst_dout",  32'(d_out), 32'h00);

    // Single byte with ts held idle
    we = 1'b1; wdata = 8'hA5;
    step();
    we = 1'b0;
    chk("single_empty_after_write", 32'(empty), 32'd0);
    chk("single_count_after_write", 32'(count), 32'd1);
    chk("single_no_load_yet",       32'(load),  32'd0);
    step();
    chk("single_load",      32'(load),  32'd1);
    chk("single_dout",      32'(d_out), 32'hA5);
    chk("single_empty",     32'(empty), 32'd1);
    chk("single_busy_load", 32'(busy),  32'd1);
    ts = 1'b0;
    step();
    chk("single_load_gone", 32'(load),  32'd0);
    chk("single_busy_wait", 32'(busy),  32'd1);
    chk("single_dout_hold", 32'(d_out), 32'hA5);
    step();
    chk("single_busy_wait2", 32'(busy), 32'd1);
    ts = 1'b1;
    step();
    chk("single_busy_idle", 32'(busy), 32'd0);
    chk("single_no_reload", 32'(load), 32'd0);

    // Burst of three, TX holds ts low for 11 cycles after each load
    wr_q  = '{8'h01, 8'h02, 8'h03};
    exp_q = '{8'h01, 8'h02, 8'h03};
    run_tx(11, 0, 200);
    step();
    step();
    chk("burst_empty", 32'(empty), 32'd1);
    chk("burst_idle",  32'(busy),  32'd0);

    // Overflow with ts held low
    ts = 1'b0;
    for (int i = 0; i <= int'(DEPTH); i++) begin
      we = 1'b1; wdata = 8'(8'h10 + i);
      step();
    end
    we = 1'b0;
    chk("ovf_full",  32'(full),  32'd1);
    chk("ovf_count", 32'(count), 32'(DEPTH));
    chk("ovf_flag",  32'(ovf),   32'd1);
    clr_ovf = 1'b1; we = 1'b1; wdata = 8'hEE;
    step();
    chk("ovf_clear_vs_drop", 32'(ovf),   32'd1);
    chk("ovf_count_hold",    32'(count), 32'(DEPTH));
    we = 1'b0;
    step();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(ovf), 32'd0);
    // Dropped write coinciding with a pop still flags overflow
    ts = 1'b1; we = 1'b1; wdata = 8'hEF;
    step();
    we = 1'b0;
    chk("ovf_drop_on_pop", 32'(ovf),   32'd1);
    chk("ovf_pop_count",   32'(count), 32'(DEPTH - 1));
    chk("ovf_pop_load",    32'(load),  32'd1);
    chk("ovf_pop_dout",    32'(d_out), 32'h10);
    ts = 1'b0; tx_cnt = 2;
    for (int i = 1; i < int'(DEPTH); i++) exp_q.push_back(8'(8'h10 + i));
    run_tx(2, 0, 300);
    step();
    step();
    chk("ovf_drain_empty", 32'(empty), 32'd1);
    chk("ovf_sticky",      32'(ovf),   32'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_final_clear", 32'(ovf), 32'd0);

    // Pointer wrap: 2*DEPTH+3 writes interleaved with drains
    for (int i = 0; i < 2 * int'(DEPTH) + 3; i++) begin
      wr_q.push_back(8'(8'h40 + i));
      exp_q.push_back(8'(8'h40 + i));
    end
    run_tx(2, 5, 1000);
    step();
    step();
    chk("wrap_empty", 32'(empty), 32'd1);
    chk("wrap_ovf",   32'(ovf),   32'd0);
    chk("wrap_idle",  32'(busy),  32'd0);

    // Simultaneous push and pop with three queued
    ts = 1'b0;
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; wdata = 8'(8'h71 + i);
      step();
    end
    chk("pp_count_pre", 32'(count), 32'd3);
    ts = 1'b1; we = 1'b1; wdata = 8'h74;
    step();
    chk("pp_count", 32'(count), 32'd3);
    chk("pp_load",  32'(load),  32'd1);
    chk("pp_dout",  32'(d_out), 32'h71);

    // Reset while in WAIT with four queued; rst overrides a write
    ts = 1'b0; we = 1'b1; wdata = 8'h75;
    step();
    we = 1'b0;
    chk("rw_count4", 32'(count), 32'd4);
    chk("rw_load0",  32'(load),  32'd0);
    step();
    rst = 1'b1; we = 1'b1; wdata = 8'h99;
    step();
    rst = 1'b0; we = 1'b0; ts = 1'b1;
    chk("rw_count", 32'(count), 32'd0);
    chk("rw_load",  32'(load),  32'd0);
    chk("rw_busy",  32'(busy),  32'd0);
    chk("rw_empty", 32'(empty), 32'd1);
    chk("rw_dout",  32'(d_out), 32'h00);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rw_no_load", 32'(load), 32'd0);
    end
    chk("rw_count_final", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
